keypad_col_decoder: RTL and testbench

Column-side keypad decoder paired with the walking-zero row scanner. It paces the scanner through a scan-enable pulse and samples the four active-low column lines while a row is held low. It debounces the press and encodes the key as a 4-bit code. The code is presented to the lock controller under a valid/ack handshake, and each physical press produces exactly one code.

---
 rtl/keypad_col_decoder.sv | 136 +++++++++++++
 tb/tb_keypad_col_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_col_decoder.sv
// Column-side keypad decoder: paces the row scanner, debounces a press and offers one code per press.
// Optional: define KEYPAD_MULTIKEY_REJECT_EN to treat several low columns as no press.
module keypad_col_decoder #(
    parameter int SETTLE_CYCLES   = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_drive,
    input  logic [3:0] col_in,
    output logic       scan_en,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack
);
    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_STEP, ST_SETTLE, ST_SAMPLE, ST_DEBOUNCE, ST_VALID, ST_RELEASE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0]    col_meta, col_s;
    logic [1:0]    cand_row, cand_col, cand_row_nx, cand_col_nx;
    logic [3:0]    code_q, code_nx;

    logic [3:0] row_low, col_low;
    logic [1:0] row_idx, col_idx;
    logic       row_ok, press;

    // Row/column decode of the current scanner pattern and synchronized columns
    always_comb begin
        row_low = ~row_drive;
        col_low = ~col_s;
        row_ok  = (row_low != 4'h0) && ((row_low & (row_low - 4'h1)) == 4'h0);
        case (row_low)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        if (col_low[0])      col_idx = 2'd0;
        else if (col_low[1]) col_idx = 2'd1;
        else if (col_low[2]) col_idx = 2'd2;
        else                 col_idx = 2'd3;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        press = (col_low != 4'h0) && ((col_low & (col_low - 4'h1)) == 4'h0);
`else
        press = (col_low != 4'h0);
`endif
        cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        cand_row_nx = cand_row;
        cand_col_nx = cand_col;
        code_nx     = code_q;
        case (state)
            ST_STEP: begin
                cnt_nx   = '0;
                state_nx = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_nx = cnt_inc;
                if (cnt == SETTLE_LAST) state_nx = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (row_ok && press) begin
                    cand_row_nx = row_idx;
                    cand_col_nx = col_idx;
                    cnt_nx      = '0;
                    state_nx    = ST_DEBOUNCE;
                end else begin
                    state_nx = ST_STEP;
                end
            end
            ST_DEBOUNCE: begin
                if (row_ok && press && (col_idx == cand_col)) begin
                    cnt_nx = cnt_inc;
                    if (cnt == DEB_LAST) begin
                        state_nx = ST_VALID;
                        code_nx  = {cand_row, cand_col};
                    end
                end else begin
                    state_nx = ST_STEP;
                end
            end
            ST_VALID: begin
                if (key_ack) begin
                    cnt_nx   = '0;
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Any low column restarts the release window, so a held key never repeats
                if (col_s == 4'hF) begin
                    cnt_nx = cnt_inc;
                    if (cnt == DEB_LAST) state_nx = ST_STEP;
                end else begin
                    cnt_nx = '0;
                end
            end
            default: state_nx = ST_STEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_SETTLE;
            cnt      <= '0;
            col_meta <= 4'hF;
            col_s    <= 4'hF;
            cand_row <= 2'd0;
            cand_col <= 2'd0;
            code_q   <= 4'h0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            col_meta <= col_in;
            col_s    <= col_meta;
            cand_row <= cand_row_nx;
            cand_col <= cand_col_nx;
            code_q   <= code_nx;
        end
    end

    assign scan_en   = (state == ST_STEP);
    assign key_valid = (state == ST_VALID);
    assign key_code  = code_q;
endmodule

// File: tb/tb_keypad_col_decoder.sv
// Bench for keypad_col_decoder: a 4x4 keypad model plus walking-zero scanner drive the DUT.
module tb_keypad_col_decoder;
    localparam int S = 3;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst, key_ack, scan_en, key_valid;
    logic [3:0] row_drive, col_in, key_code;
    logic [15:0] keys;  // bit r*4+c set = key at row r, column c held down

    int total = 0, bad = 0;
    int cyc_n = 0, last_se = -100, n_se = 0, n_vrise = 0, n_xfer = 0, rowp = 0;
    logic [3:0] last_xcode = 4'h0, code_prev = 4'h0;
    logic vld_prev = 1'b0, se_prev = 1'b0;

    keypad_col_decoder #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .row_drive(row_drive), .col_in(col_in),
        .scan_en(scan_en), .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] keypad(input logic [3:0] rd, input logic [15:0] k);
        logic [3:0] cols = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!rd[r])
                for (int c = 0; c < 4; c++)
                    if (k[r*4+c]) cols[c] = 1'b0;
        return cols;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        col_in = keypad(row_drive, keys);
    endtask

    // One clock: note handshake before the edge, then advance scanner and keypad just after it
    task automatic cyc();
        logic se_b, xf_b, rst_b;
        se_b  = scan_en;
        rst_b = rst;
        xf_b  = key_valid && key_ack && !rst;
        if (xf_b === 1'b1) begin
            n_xfer++;
            last_xcode = key_code;
        end
        vld_prev  = key_valid;
        se_prev   = scan_en;
        code_prev = key_code;
        @(posedge clk);
        #1;
        cyc_n++;
        if (rst_b) rowp = 0;
        else if (se_b === 1'b1) rowp = (rowp + 1) % 4;
        row_drive = ~(4'b0001 << rowp);
        upd();
        if (scan_en === 1'b1) begin
            n_se++;
            last_se = cyc_n;
            chk("scan_single", se_prev, 0);
            chk("scan_vs_valid", key_valid, 0);
        end
        if (key_valid === 1'b1 && vld_prev === 1'b1) chk("code_stable", key_code, code_prev);
        if (key_valid === 1'b1 && vld_prev !== 1'b1) n_vrise++;
    endtask

    task automatic check_reset_scan();
        for (int i = 0; i < S + 1; i++) begin
            chk("rst_scan_quiet", scan_en, 0);
            chk("rst_valid_low", key_valid, 0);
            cyc();
        end
        chk("rst_first_scan", scan_en, 1);
    endtask

    task automatic press(input int r, input logic [3:0] cols);
        for (int i = 0; i < 10 && rowp == r; i++) cyc();
        chk("press_row_away", (rowp != r), 1);
        keys = keys | (16'(cols) << (4 * r));
        upd();
    endtask

    // Wait for the code, check latency and hold, ack after ack_dly cycles, release either at
    // rel_at cycles into VALID or hold cycles after the handshake, then check scanning resumes.
    task automatic take_key(input logic [3:0] exp, input int ack_dly, input int rel_at, input int hold);
        int h, c, se0, vr0, xf0, tgt, n;
        vr0 = n_vrise;
        n = 0;
        while (key_valid !== 1'b1 && n < 120) begin
            cyc();
            n++;
        end
        chk("valid_seen", key_valid, 1);
        chk("valid_latency", cyc_n - last_se, S + 2 + D);
        chk("valid_once", n_vrise - vr0, 1);
        xf0 = n_xfer;
        c = -1;
        for (int k = 0; k <= ack_dly; k++) begin
            if (k == rel_at) begin
                keys = '0;
                upd();
                c = cyc_n;
            end
            chk("valid_held", key_valid, 1);
            chk("code", key_code, exp);
            if (k == ack_dly) key_ack = 1'b1;
            cyc();
        end
        key_ack = 1'b0;
        h = cyc_n - 1;
        vr0 = n_vrise;
        se0 = n_se;
        chk("valid_drop", key_valid, 0);
        chk("scan_after_ack", scan_en, 0);
        chk("xfer_once", n_xfer - xf0, 1);
        chk("xfer_code", last_xcode, exp);
        chk("code_kept", key_code, exp);
        if (c < 0) begin
            for (int k = 0; k < hold; k++) cyc();
            keys = '0;
            upd();
            c = cyc_n;
        end
        tgt = ((c + 2 > h + 1) ? c + 2 : h + 1) + D;
        while (cyc_n < tgt) cyc();
        chk("rel_scan_resume", scan_en, 1);
        chk("rel_no_early_scan", n_se - se0, 1);
        chk("no_second_code", n_vrise - vr0, 0);
    endtask

    initial begin
        int n, vr0, xf0;
        rst = 1'b1;
        key_ack = 1'b0;
        keys = '0;
        row_drive = 4'b1110;
        upd();
        cyc();
        cyc();
        chk("rst_scan_en", scan_en, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_code", key_code, 0);
        rst = 1'b0;
        check_reset_scan();

        // clean press, row 2 col 1, immediate ack
        press(2, 4'b0010);
        take_key(4'h9, 0, 100, 0);

        // bounce on row 1 col 2 right after the scanner steps onto row 1
        n = 0;
        while (!(rowp == 1 && last_se == cyc_n - 1) && n < 40) begin
            cyc();
            n++;
        end
        chk("bounce_sync", rowp, 1);
        vr0 = n_vrise;
        keys = 16'h0040; upd();
        cyc(); cyc();
        keys = 16'h0000; upd();
        cyc();
        keys = 16'h0040; upd();
        cyc();
        chk("bounce_no_step_yet", scan_en, 0);
        cyc();
        chk("bounce_abort_step", scan_en, 1);
        chk("bounce_no_valid", n_vrise - vr0, 0);
        take_key(4'h6, 2, 100, 3);

        // early release, late ack
        press(0, 4'b1000);
        take_key(4'h3, 10, 1, 0);

        // key held long after the handshake
        press(3, 4'b0100);
        take_key(4'hE, 0, 100, 100);

        // two columns low on row 1
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        press(1, 4'b0101);
        vr0 = n_vrise;
        repeat (60) cyc();
        chk("multi_rejected", n_vrise - vr0, 0);
        keys = '0;
        upd();
        repeat (5) cyc();
`else
        press(1, 4'b0101);
        take_key(4'h4, 1, 100, 2);
`endif

        // random single presses with random ack/release timing
        for (int it = 0; it < 10; it++) begin
            int r, c, ad, ra, hd;
            r  = $urandom_range(0, 3);
            c  = $urandom_range(0, 3);
            ad = $urandom_range(0, 6);
            ra = $urandom_range(0, ad + 3);
            hd = $urandom_range(0, 4);
            press(r, 4'(1 << c));
            take_key(4'(r * 4 + c), ad, ra, hd);
        end

        // reset while a code is offered, with ack asserted in the same cycle
        press(2, 4'b0001);
        n = 0;
        while (key_valid !== 1'b1 && n < 120) begin
            cyc();
            n++;
        end
        chk("rst_pre_valid", key_valid, 1);
        chk("rst_pre_code", key_code, 4'h8);
        xf0 = n_xfer;
        rst = 1'b1;
        key_ack = 1'b1;
        keys = '0;
        upd();
        cyc();
        chk("rst_drop_valid", key_valid, 0);
        chk("rst_code_clear", key_code, 0);
        chk("rst_scan_low", scan_en, 0);
        cyc();
        rst = 1'b0;
        key_ack = 1'b0;
        chk("rst_no_xfer", n_xfer - xf0, 0);
        check_reset_scan();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
